gbf_pingpong_ctrl: RTL and testbench

GBF_PINGPONG_CTRL -- requirements
Module: gbf_pingpong_ctrl

---
 rtl/gbf_pingpong_ctrl_pkg.sv | 7 +
 rtl/simple_dp_ram.sv | 22 ++
 rtl/gbf_pingpong_ctrl.sv | 91 +++++++++
 tb/tb_gbf_pingpong_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbf_pingpong_ctrl_pkg.sv
// gbf_pingpong_ctrl_pkg: bank state type and default buffer geometry
package gbf_pingpong_ctrl_pkg;
  localparam int DEF_DATA_BITWIDTH = 512;
  localparam int DEF_ADDR_BITWIDTH = 5;
  localparam int DEF_DEPTH = 32;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
endpackage

// File: rtl/simple_dp_ram.sv
// simple_dp_ram: gbf buffer bank, port A write and port B registered read, both on negedge
module simple_dp_ram
  import gbf_pingpong_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wea,
  input  logic [ADDR_BITWIDTH-1:0] addra,
  input  logic [DATA_BITWIDTH-1:0] dina,
  input  logic                     enb,
  input  logic [ADDR_BITWIDTH-1:0] addrb,
  output logic [DATA_BITWIDTH-1:0] doutb
);
  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  always_ff @(negedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) doutb <= mem[addrb];
  end
endmodule

// File: rtl/gbf_pingpong_ctrl.sv
// gbf_pingpong_ctrl: two-bank ping-pong buffer, fills one bank while draining the other
module gbf_pingpong_ctrl
  import gbf_pingpong_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic [1:0]               bank_full,
  output logic                     drain_done
);
  localparam logic [ADDR_BITWIDTH-1:0] LAST = ADDR_BITWIDTH'(DEPTH - 1);
  bank_state_e st [2];
  logic wb, rb;
  logic [ADDR_BITWIDTH-1:0] wa, ra;
  logic [DATA_BITWIDTH-1:0] rdata [2];
  logic [DATA_BITWIDTH-1:0] fifo [2];
  logic fifo_rp, fifo_wp;
  logic [1:0] cnt;
  logic wr_fire, rd_fire, pop, last_wr, last_rd;
  // RAM data read mid-cycle on the negedge is ready to enter the FIFO at the closing posedge
  always_comb begin
    in_ready = st[wb] == EMPTY || st[wb] == FILLING;
    out_valid = cnt != 2'd0;
    out_data = fifo[fifo_rp];
    wr_fire = in_valid && in_ready;
    pop = out_valid && out_ready;
    rd_fire = st[rb] == DRAINING && (cnt < 2'd2 || pop);
    last_wr = wr_fire && wa == LAST;
    last_rd = rd_fire && ra == LAST;
  end
  for (genvar i = 0; i < 2; i++) begin : g_bank
    simple_dp_ram #(
      .DATA_BITWIDTH(DATA_BITWIDTH),
      .ADDR_BITWIDTH(ADDR_BITWIDTH),
      .DEPTH(DEPTH)
    ) u_ram (
      .clk,
      .wea(wr_fire && wb == 1'(i)),
      .addra(wa),
      .dina(in_data),
      .enb(rd_fire && rb == 1'(i)),
      .addrb(ra),
      .doutb(rdata[i])
    );
    assign bank_full[i] = st[i] == FULL || st[i] == DRAINING;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      {wb, rb, wa, ra, fifo_rp, fifo_wp, cnt, drain_done} <= '0;
    end else if (flush) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      {wb, rb, wa, ra, fifo_rp, fifo_wp, cnt, drain_done} <= '0;
    end else begin
      drain_done <= last_rd;
      // wb and rb only share a bank when its state excludes the other side's update
      if (wr_fire) begin
        st[wb] <= last_wr ? FULL : FILLING;
        wa <= last_wr ? '0 : wa + 1'b1;
        if (last_wr) wb <= ~wb;
      end
      if (st[rb] == FULL) begin
        st[rb] <= DRAINING;
        ra <= '0;
      end
      if (rd_fire) begin
        ra <= last_rd ? '0 : ra + 1'b1;
        fifo_wp <= ~fifo_wp;
        if (last_rd) begin
          st[rb] <= EMPTY;
          rb <= ~rb;
        end
      end
      if (pop) fifo_rp <= ~fifo_rp;
      cnt <= cnt + {1'b0, rd_fire} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (rd_fire) fifo[fifo_wp] <= rdata[rb];
endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
// tb_gbf_pingpong_ctrl: directed checks of fill, drain, streaming, backpressure, flush and reset
module tb_gbf_pingpong_ctrl;
  logic clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready, drain_done;
  logic [511:0] in_data, out_data;
  logic [1:0] bank_full;
  int vec = 0, err = 0;

  gbf_pingpong_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bank_full(bank_full), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vec++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    step();
    rst = 0;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data = base + i;
      chk("fill_ready", in_ready, 1);
      step();
    end
    in_valid = 0;
  endtask

  task automatic drain_check(input int base);
    int dd = 0;
    chk("full_bank0", bank_full, 2'b01);
    chk("ov_edge0", out_valid, 0);
    step();
    chk("ov_edge1", out_valid, 0);
    step();
    for (int k = 0; k < 32; k++) begin
      chk("ov_drain", out_valid, 1);
      chk("drain_data", out_data, base + k);
      chk("drain_done", drain_done, k == 31);
      dd += int'(drain_done);
      step();
    end
    chk("ov_after", out_valid, 0);
    chk("bank_full_after", bank_full, 0);
    chk("drain_done_once", dd, 1);
  endtask

  initial begin
    int wr, rd, n, ex, dd, extra;
    int order[$];
    logic [1:0] prev;
    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_drain_done", drain_done, 0);
    rst = 0;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // single bank fill and drain
    do_reset();
    out_ready = 1;
    fill(32, 0);
    drain_check(0);

    // continuous streaming over three bank fills
    do_reset();
    out_ready = 1;
    wr = 0; rd = 0; prev = 2'b00;
    for (int c = 0; c < 400 && rd < 96; c++) begin
      in_valid = wr < 96;
      in_data = wr;
      if (out_valid) begin
        chk("stream_data", out_data, rd);
        rd++;
      end
      if (!in_ready) chk("stream_ready_drop", bank_full, 2'b11);
      for (int i = 0; i < 2; i++) if (bank_full[i] && !prev[i]) order.push_back(i);
      prev = bank_full;
      if (in_valid && in_ready) wr++;
      step();
    end
    in_valid = 0;
    chk("stream_count", rd, 96);
    chk("bank_order_len", order.size(), 3);
    if (order.size() == 3) begin
      chk("bank_order0", order[0], 0);
      chk("bank_order1", order[1], 1);
      chk("bank_order2", order[2], 0);
    end

    // downstream stall for 10 cycles mid-drain
    do_reset();
    out_ready = 1;
    fill(32, 100);
    ex = 0; dd = 0;
    for (int c = 0; c < 200 && ex < 32; c++) begin
      out_ready = !(c >= 6 && c < 16);
      if (out_valid) begin
        chk("stall_data", out_data, 100 + ex);
        if (out_ready) ex++;
      end
      if (!out_ready) begin
        chk("stall_ov", out_valid, 1);
        chk("fifo_le2", dut.cnt <= 2'd2, 1);
      end
      dd += int'(drain_done);
      step();
    end
    chk("stall_count", ex, 32);
    chk("stall_drain_done", dd, 1);
    chk("stall_empty", out_valid, 0);

    // both banks occupied blocks writes
    do_reset();
    out_ready = 0;
    fill(64, 0);
    chk("both_full", bank_full, 2'b11);
    in_valid = 1;
    in_data = 512'hdead;
    for (int i = 0; i < 3; i++) begin
      chk("blocked_ready", in_ready, 0);
      step();
    end
    in_valid = 0;
    chk("still_full", bank_full, 2'b11);
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 300 && n < 64; c++) begin
      if (out_valid) begin
        chk("full_drain_data", out_data, n);
        n++;
      end
      step();
    end
    chk("full_drain_count", n, 64);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      extra += int'(out_valid);
      step();
    end
    chk("no_extra_word", extra, 0);
    chk("ready_again", in_ready, 1);

    // flush at write word 17 of bank 1 and read word 5 of bank 0
    do_reset();
    out_ready = 0;
    fill(32, 0);
    fill(17, 32);
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 60 && !(out_valid && out_data == 5); c++) begin
      if (out_valid) begin
        chk("pre_flush_data", out_data, n);
        n++;
      end
      step();
    end
    chk("pre_flush_count", n, 5);
    chk("at_word5", out_data, 5);
    flush = 1;
    in_valid = 1;
    in_data = 32 + 17;
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_ov", out_valid, 0);
    chk("flush_bank_full", bank_full, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_drain_done", drain_done, 0);
    fill(32, 200);
    drain_check(200);

    // asynchronous reset mid-drain
    do_reset();
    out_ready = 1;
    fill(32, 0);
    for (int i = 0; i < 5; i++) step();
    chk("pre_arst_ov", out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_bank_full", bank_full, 0);
    chk("arst_drain_done", drain_done, 0);
    step();
    rst = 0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      extra += int'(out_valid);
      step();
    end
    chk("post_arst_silent", extra, 0);
    chk("post_arst_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
